// File: rtl/sys_reset_ctrl_if.sv
// Reset-request inputs and reset/boot status outputs of sys_reset_ctrl.
// The slave modport is the controller's view; master is the driving side.
interface sys_reset_ctrl_if #(
    parameter int unsigned NUM_SRC = 2
);
    logic               pll_locked;
    logic [NUM_SRC-1:0] src_reset;
    logic [NUM_SRC-1:0] src_mask;
    logic               wdt_kick;
    logic               cause_clr;
    logic               sys_reset_n;
    logic               fetch_enable;
    logic [1:0]         state;
    logic [NUM_SRC+2:0] reset_cause;

    modport master (
        output pll_locked, src_reset, src_mask, wdt_kick, cause_clr,
        input  sys_reset_n, fetch_enable, state, reset_cause
    );

    modport slave (
        input  pll_locked, src_reset, src_mask, wdt_kick, cause_clr,
        output sys_reset_n, fetch_enable, state, reset_cause
    );
endinterface

// File: rtl/sys_reset_ctrl.sv
// Reset and boot sequencer: merges PLL lock and reset requests into a stretched
// system reset, delays fetch enable, records sticky causes. Watchdog: RSTCTRL_WDT_EN.
module sys_reset_ctrl #(
    parameter int unsigned NUM_SRC     = 2,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned HOLD_CYCLES = 16,
    parameter int unsigned FETCH_DELAY = 8,
    parameter int unsigned WDT_CYCLES  = 1000
) (
    input  logic             CLK,
    input  logic             RESET_N,
    sys_reset_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        HOLD      = 2'd1,
        RUN_WAIT  = 2'd2,
        RUN       = 2'd3
    } state_e;

    localparam int unsigned      CW         = NUM_SRC + 3;
    localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] FETCH_LOAD = CNT_W'(FETCH_DELAY - 1);

    state_e                              state_q, state_d;
    logic [CNT_W-1:0]                    cnt_q, cnt_d;
    logic [SYNC_STAGES-1:0]              lock_sync_q, lock_sync_d;
    logic [SYNC_STAGES-1:0][NUM_SRC-1:0] src_sync_q, src_sync_d;
    logic [CW-1:0]                       cause_q, cause_d;
    logic                                sys_reset_n_q, sys_reset_n_d;
    logic                                fetch_enable_q, fetch_enable_d;

    logic               lock_s;
    logic [NUM_SRC-1:0] src_act;
    logic               active;
    logic               wdt_expire;
    logic [CW-1:0]      cause_set;

    assign lock_s  = lock_sync_q[SYNC_STAGES-1];
    assign src_act = src_sync_q[SYNC_STAGES-1] & bus.src_mask;
    assign active  = |src_act;

    always_comb begin
        lock_sync_d   = {lock_sync_q[SYNC_STAGES-2:0], bus.pll_locked};
        src_sync_d    = src_sync_q;
        src_sync_d[0] = bus.src_reset;
        for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
            src_sync_d[i] = src_sync_q[i-1];
        end
    end

`ifdef RSTCTRL_WDT_EN
    localparam logic [CNT_W-1:0] WDT_LOAD = CNT_W'(WDT_CYCLES - 1);

    logic [CNT_W-1:0] wdt_q, wdt_d;

    // A kick on the expiry cycle wins over the timeout.
    assign wdt_expire = (state_q == RUN) && !bus.wdt_kick && (wdt_q == '0);

    always_comb begin
        wdt_d = wdt_q;
        if (state_q == RUN_WAIT && state_d == RUN) begin
            wdt_d = WDT_LOAD;
        end else if (state_q == RUN) begin
            if (bus.wdt_kick) begin
                wdt_d = WDT_LOAD;
            end else if (wdt_q != '0) begin
                wdt_d = wdt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            wdt_q <= '0;
        end else begin
            wdt_q <= wdt_d;
        end
    end
`else
    localparam int unsigned wdt_cycles_unused = WDT_CYCLES;
    logic unused_wdt_kick;

    assign unused_wdt_kick = bus.wdt_kick;
    assign wdt_expire      = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cause_set = '0;
        case (state_q)
            WAIT_LOCK: begin
                if (lock_s) begin
                    state_d = HOLD;
                    cnt_d   = HOLD_LOAD;
                end
            end
            HOLD: begin
                if (!lock_s) begin
                    state_d = WAIT_LOCK;
                end else if (active) begin
                    cnt_d = HOLD_LOAD;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    state_d = RUN_WAIT;
                    cnt_d   = FETCH_LOAD;
                end
            end
            RUN_WAIT, RUN: begin
                // Lock loss outranks sources and watchdog for the next state, but
                // every coincident cause is still recorded.
                if (!lock_s || active || wdt_expire) begin
                    cause_set[1]      = !lock_s;
                    cause_set[2]      = wdt_expire;
                    cause_set[CW-1:3] = src_act;
                    if (!lock_s) begin
                        state_d = WAIT_LOCK;
                    end else begin
                        state_d = HOLD;
                        cnt_d   = HOLD_LOAD;
                    end
                end else if (state_q == RUN_WAIT) begin
                    if (cnt_q == '0) begin
                        state_d = RUN;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end
            default: begin
                state_d = WAIT_LOCK;
            end
        endcase

        sys_reset_n_d  = (state_d == RUN_WAIT) || (state_d == RUN);
        fetch_enable_d = (state_d == RUN);
        cause_d        = (bus.cause_clr ? '0 : cause_q) | cause_set;
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q        <= WAIT_LOCK;
            cnt_q          <= '0;
            lock_sync_q    <= '0;
            src_sync_q     <= '0;
            cause_q        <= CW'(1);
            sys_reset_n_q  <= 1'b0;
            fetch_enable_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            lock_sync_q    <= lock_sync_d;
            src_sync_q     <= src_sync_d;
            cause_q        <= cause_d;
            sys_reset_n_q  <= sys_reset_n_d;
            fetch_enable_q <= fetch_enable_d;
        end
    end

    assign bus.sys_reset_n  = sys_reset_n_q;
    assign bus.fetch_enable = fetch_enable_q;
    assign bus.state        = state_q;
    assign bus.reset_cause  = cause_q;
endmodule

// File: tb/tb_sys_reset_ctrl.sv
// Bench for sys_reset_ctrl: directed power-up/source/mask/lock/watchdog scenarios
// plus random traffic, checked against an elapsed-cycle reference model.
module tb_sys_reset_ctrl;
    localparam int NS = 2;
    localparam int SS = 2;
    localparam int HC = 16;
    localparam int FD = 8;
    localparam int WD = 1000;
    localparam int CW = NS + 3;

    logic CLK = 1'b0;
    logic RESET_N;

    always #5 CLK = ~CLK;

    sys_reset_ctrl_if #(.NUM_SRC(NS)) bus ();

    sys_reset_ctrl #(
        .NUM_SRC(NS), .SYNC_STAGES(SS), .CNT_W(16),
        .HOLD_CYCLES(HC), .FETCH_DELAY(FD), .WDT_CYCLES(WD)
    ) dut (
        .CLK(CLK),
        .RESET_N(RESET_N),
        .bus(bus)
    );

    int unsigned vec_cnt = 0;
    int unsigned err_cnt = 0;

    // Model: state code, clean cycles seen in HOLD, cycles spent in RUN_WAIT,
    // cycles since last watchdog load, sticky causes, input delay lines.
    int            m_state, m_quiet, m_wait, m_since;
    logic [CW-1:0] m_cause;
    logic [SS-1:0] m_lock_h;
    logic [NS-1:0] m_src_h [SS];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state  = 0;
        m_quiet  = 0;
        m_wait   = 0;
        m_since  = 0;
        m_cause  = CW'(1);
        m_lock_h = '0;
        for (int i = 0; i < SS; i++) m_src_h[i] = '0;
    endtask

    task automatic model_edge();
        logic          lock_s;
        logic [NS-1:0] act;
        logic          expire;
        logic [CW-1:0] set;
        int            nxt;
        if (RESET_N !== 1'b1) begin
            model_reset();
            return;
        end
        lock_s = m_lock_h[SS-1];
        act    = m_src_h[SS-1] & bus.src_mask;
        expire = 1'b0;
        set    = '0;
        nxt    = m_state;
`ifdef RSTCTRL_WDT_EN
        expire = (m_state == 3) && !bus.wdt_kick && (m_since == WD - 1);
`endif
        if (m_state == 0) begin
            if (lock_s) begin
                nxt = 1;
                m_quiet = 0;
            end
        end else if (m_state == 1) begin
            if (!lock_s) nxt = 0;
            else if (act != 0) m_quiet = 0;
            else begin
                m_quiet++;
                if (m_quiet == HC) begin
                    nxt = 2;
                    m_wait = 0;
                end
            end
        end else if (!lock_s || act != 0 || expire) begin
            set[1]      = !lock_s;
            set[2]      = expire;
            set[CW-1:3] = act;
            nxt         = lock_s ? 1 : 0;
            m_quiet     = 0;
        end else if (m_state == 2) begin
            m_wait++;
            if (m_wait == FD) begin
                nxt = 3;
                m_since = 0;
            end
        end else begin
            if (bus.wdt_kick) m_since = 0;
            else m_since++;
        end
        m_cause  = (bus.cause_clr ? '0 : m_cause) | set;
        m_state  = nxt;
        m_lock_h = {m_lock_h[SS-2:0], bus.pll_locked};
        for (int i = SS - 1; i > 0; i--) m_src_h[i] = m_src_h[i-1];
        m_src_h[0] = bus.src_reset;
    endtask

    task automatic compare_all();
        check_val("state", 32'(bus.state), 32'(m_state));
        check_val("sys_reset_n", 32'(bus.sys_reset_n), 32'(m_state >= 2));
        check_val("fetch_enable", 32'(bus.fetch_enable), 32'(m_state == 3));
        check_val("reset_cause", 32'(bus.reset_cause), 32'(m_cause));
    endtask

    task automatic step();
        @(posedge CLK);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic wait_run();
        for (int i = 0; i < 200 && bus.state != 2'd3; i++) step();
        check_val("reach_run", 32'(bus.state), 32'd3);
    endtask

    task automatic async_reset();
        RESET_N = 1'b0;
        model_reset();
        #2;
        compare_all();
        step();
        step();
        RESET_N = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        int drop_left;
        bus.pll_locked = 1'b1;
        bus.src_reset  = '0;
        bus.src_mask   = '1;
        bus.wdt_kick   = 1'b0;
        bus.cause_clr  = 1'b0;
        RESET_N        = 1'b1;
        model_reset();
        #1 RESET_N = 1'b0;
        #1 compare_all();
        check_val("por_cause", 32'(bus.reset_cause), 32'd1);
        repeat (3) step();
        RESET_N = 1'b1;

        // Power-up: HOLD at edge 3, reset release at 19, fetch at 27
        for (int e = 1; e <= 30; e++) begin
            step();
            if (e == 2)  check_val("pu_state_e2", 32'(bus.state), 32'd0);
            if (e == 3)  check_val("pu_state_e3", 32'(bus.state), 32'd1);
            if (e == 18) check_val("pu_srst_e18", 32'(bus.sys_reset_n), 32'd0);
            if (e == 19) check_val("pu_srst_e19", 32'(bus.sys_reset_n), 32'd1);
            if (e == 26) check_val("pu_fetch_e26", 32'(bus.fetch_enable), 32'd0);
            if (e == 27) check_val("pu_fetch_e27", 32'(bus.fetch_enable), 32'd1);
        end
        check_val("pu_cause", 32'(bus.reset_cause), 32'b00001);

        // Source reset pulse on src_reset[1]
        bus.src_reset = 2'b10;
        for (int i = 1; i <= 5; i++) begin
            step();
            if (i == 2) check_val("src_srst_e2", 32'(bus.sys_reset_n), 32'd1);
            if (i == 3) check_val("src_srst_e3", 32'(bus.sys_reset_n), 32'd0);
        end
        bus.src_reset = '0;
        repeat (40) step();
        check_val("src_state", 32'(bus.state), 32'd3);
        check_val("src_cause", 32'(bus.reset_cause), 32'b10001);

        // Masked source ignored, then clear coinciding with a set
        bus.src_mask  = 2'b10;
        bus.src_reset = 2'b01;
        repeat (50) step();
        check_val("mask_state", 32'(bus.state), 32'd3);
        bus.src_reset = 2'b10;
        step();
        step();
        bus.cause_clr = 1'b1;
        step();
        bus.cause_clr = 1'b0;
        check_val("clr_set_cause", 32'(bus.reset_cause), 32'b10000);
        check_val("clr_set_state", 32'(bus.state), 32'd1);
        bus.src_reset = '0;
        wait_run();

        // Lock loss with a coincident source request
        bus.pll_locked = 1'b0;
        bus.src_reset  = 2'b10;
        repeat (10) step();
        check_val("lock_state", 32'(bus.state), 32'd0);
        check_val("lock_cause", 32'(bus.reset_cause), 32'b10010);
        bus.pll_locked = 1'b1;
        bus.src_reset  = '0;
        for (int e = 1; e <= 30; e++) begin
            step();
            if (e == 3)  check_val("relock_state_e3", 32'(bus.state), 32'd1);
            if (e == 19) check_val("relock_srst_e19", 32'(bus.sys_reset_n), 32'd1);
            if (e == 27) check_val("relock_fetch_e27", 32'(bus.fetch_enable), 32'd1);
        end

`ifdef RSTCTRL_WDT_EN
        for (int i = 0; i < 10000; i++) begin
            bus.wdt_kick = (i % 900 == 899);
            step();
        end
        check_val("wdt_kicked_state", 32'(bus.state), 32'd3);
        bus.wdt_kick = 1'b1;
        step();
        bus.wdt_kick = 1'b0;
        n = 0;
        for (int i = 0; i < 1200 && bus.state != 2'd1; i++) begin
            step();
            n++;
        end
        check_val("wdt_expiry_cycles", 32'(n), 32'd1000);
        check_val("wdt_cause", 32'(bus.reset_cause), 32'b10110);
        wait_run();
`else
        for (int i = 0; i < 3000; i++) begin
            bus.wdt_kick = ($urandom_range(0, 9) == 0);
            step();
        end
        bus.wdt_kick = 1'b0;
        check_val("nowdt_state", 32'(bus.state), 32'd3);
        check_val("nowdt_cause_bit2", 32'(bus.reset_cause[2]), 32'd0);
`endif

        // Random traffic
        drop_left = 0;
        for (int i = 0; i < 4000; i++) begin
            if (drop_left > 0) begin
                drop_left--;
                bus.pll_locked = (drop_left == 0);
            end else if ($urandom_range(0, 299) == 0) begin
                drop_left = int'($urandom_range(1, 20));
                bus.pll_locked = 1'b0;
            end
            for (int b = 0; b < NS; b++) begin
                if ($urandom_range(0, 79) == 0) bus.src_reset[b] = ~bus.src_reset[b];
            end
            if ($urandom_range(0, 499) == 0) bus.src_mask = NS'($urandom);
            bus.wdt_kick  = ($urandom_range(0, 599) == 0);
            bus.cause_clr = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 1499) == 0) async_reset();
            else step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
